// File: rtl/cache_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cache_reader
//  Purpose  : Streams one frame of 2^ADDR_W words out of a frame memory in
//             linear or bit-reversed address order over a valid/ready port.
//             A 2-entry output buffer plus one cycle of read latency lets the
//             block sustain one beat per clock while honouring backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module cache_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_rev,
  output logic [ADDR_W-1:0] mem_read_adr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  // State encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  // Highest frame index and increment constant
  localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Control state
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_bit_rev;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_rev_idx;

  // Read pipeline: one read may be outstanding against the memory
  logic              r_inflight;
  logic              r_inflight_last;

  // 2-entry output FIFO
  logic [DATA_W-1:0] r_buf_data [2];
  logic [1:0]        r_buf_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_done;

  // Handshake / issue decisions
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_frame_end;
  logic              w_start_frame;

  // Bit-reversed view of the index: bit k maps to bit ADDR_W-1-k
  for (genvar k = 0; k < ADDR_W; k++) begin : g_rev
    assign w_rev_idx[k] = r_idx[ADDR_W-1-k];
  end

  assign w_valid       = (r_count != 2'd0);
  assign w_pop         = w_valid & m_ready;
  assign w_start_frame = (r_state == c_ST_IDLE) & start;

  // A read is allowed only while the buffer can still absorb it, counting
  // the read already in flight and any entry leaving this cycle. Compared
  // as count + inflight < 2 + pop to stay in unsigned arithmetic.
  assign w_issue      = (r_state == c_ST_READ) &&
                        (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_issue_last = w_issue & (r_idx == c_LAST_IDX);

  // The frame ends with the beat that carries the last index
  assign w_frame_end  = (r_state == c_ST_DRAIN) & w_pop & r_buf_last[r_rd_ptr];

  // Address follows the index in the order latched at start
  assign mem_read_adr = r_bit_rev ? w_rev_idx : r_idx;

  // Stream port is driven straight from the buffer head so it holds
  // steady while the sink stalls
  assign m_data  = r_buf_data[r_rd_ptr];
  assign m_valid = w_valid;
  assign m_last  = w_valid & r_buf_last[r_rd_ptr];
  assign done    = r_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start)        w_state_nxt = c_ST_READ;
      c_ST_READ:  if (w_issue_last) w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: if (w_frame_end)  w_state_nxt = c_ST_IDLE;
      default:                      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy      = 1'b0;
    mem_rd_en = 1'b0;
    case (r_state)
      c_ST_READ: begin
        busy      = 1'b1;
        mem_rd_en = w_issue;
      end
      c_ST_DRAIN: begin
        busy      = 1'b1;
      end
      default: begin
        busy      = 1'b0;
        mem_rd_en = 1'b0;
      end
    endcase
  end

  // Frame index and order select: latched at start, stepped on each read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_bit_rev <= 1'b0;
    end else if (w_start_frame) begin
      r_idx     <= '0;
      r_bit_rev <= bit_rev;
    end else if (w_issue) begin
      r_idx     <= r_idx + c_IDX_ONE;
    end
  end

  // Track the read whose data lands on the next edge, with its last-index tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
    end
  end

  // Output FIFO: capture returning read data, retire entries on each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
      end
      r_buf_last <= 2'b00;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= mem_read_data;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Completion pulse in the cycle after the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cache_reader
//  Purpose  : Self-checking bench for cache_reader. Stimulus pushes each
//             frame's expected beats into a queue; a monitor pops and compares
//             on every accepted beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_reader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int N      = 1 << ADDR_W;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic              bit_rev = 1'b0;
  logic              m_ready = 1'b1;
  logic [ADDR_W-1:0] mem_read_adr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [N];
  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W-1:0] first_data [4];

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  bit bp     = 1'b0;

  cache_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bit_rev       (bit_rev),
    .mem_read_adr  (mem_read_adr),
    .mem_rd_en     (mem_rd_en),
    .mem_read_data (mem_read_data),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Registered frame memory, preloaded with MEM[i] = i
  initial begin
    for (int i = 0; i < N; i++) mem[i] = DATA_W'(i);
    mem_read_data = '0;
  end
  always @(posedge clk) if (mem_rd_en) mem_read_data <= mem[mem_read_adr];

  // Sink readiness: always ready, or a coin flip per cycle under backpressure
  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [ADDR_W-1:0] rev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int k = 0; k < ADDR_W; k++) r[k] = a[ADDR_W-1-k];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop, stall stability, done timing, read throttling
  initial begin
    int occ;
    int infl;
    bit prev_stall;
    bit exp_done;
    bit pop;
    logic [DATA_W-1:0] pd;
    logic pl;
    logic [DATA_W:0] e;
    occ = 0; infl = 0; prev_stall = 0; exp_done = 0; pd = '0; pl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ = 0; infl = 0; prev_stall = 0; exp_done = 0;
        continue;
      end
      pop = m_valid && m_ready;
      if (mem_rd_en) begin
        checks++;
        if (occ + infl - int'(pop) >= 2) begin
          errors++;
          $display("FAIL read_throttle: read issued with occ=%0d inflight=%0d pop=%0d at %0t",
                   occ, infl, pop, $time);
        end
      end
      if (prev_stall) begin
        checks++;
        if (!(m_valid === 1'b1 && m_data === pd && m_last === pl)) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b at %0t",
                   m_valid, m_data, m_last, pd, pl, $time);
        end
      end
      if (done || exp_done) check("done_pulse", 32'(done), 32'(exp_done));
      if (pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data %0h expected no beat at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e[DATA_W-1:0]));
          check("beat_last", 32'(m_last), 32'(e[DATA_W]));
        end
        if (beats < 4) first_data[beats] = m_data;
        beats++;
      end
      exp_done   = pop && m_last;
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      occ  = occ + infl - int'(pop);
      infl = int'(mem_rd_en);
    end
  end

  // Queue the expected frame and issue start; entered and left at posedge+1
  task automatic start_frame(input bit br);
    logic [ADDR_W-1:0] a;
    beats = 0;
    for (int i = 0; i < N; i++) begin
      a = br ? rev(ADDR_W'(i)) : ADDR_W'(i);
      exp_q.push_back({(i == N - 1), mem[a]});
    end
    start   = 1'b1;
    bit_rev = br;
    @(posedge clk); #1;
    start   = 1'b0;
    bit_rev = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_lat_c0", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_lat_c1", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_lat_c2", 32'(m_valid), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("beats_per_frame", 32'(beats), 32'(N));
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats < target && n < 4 * N) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_beat", 32'(beats >= target), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_last"},  32'(m_last), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_adr"},   32'(mem_read_adr), 32'd0);
    check({tag, "_data"},  32'(m_data), 32'd0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b1;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Linear order
    start_frame(1'b0);
    wait_done(N + 50);
    @(posedge clk); #1;

    // Bit-reversed order, with hand-computed leading beats
    start_frame(1'b1);
    wait_done(N + 50);
    check("brev_beat0", 32'(first_data[0]), 32'd0);
    check("brev_beat1", 32'(first_data[1]), 32'd2048);
    check("brev_beat2", 32'(first_data[2]), 32'd1024);
    check("brev_beat3", 32'(first_data[3]), 32'd3072);
    @(posedge clk); #1;

    // Random backpressure, linear order
    bp = 1'b1;
    start_frame(1'b0);
    wait_done(8 * N);
    bp = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Start pulse mid-frame must be ignored
    start_frame(1'b0);
    wait_beats(100);
    start   = 1'b1;
    bit_rev = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    bit_rev = 1'b0;
    wait_done(N + 50);
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_ignored_valid", 32'(m_valid), 32'd0);
    check("idle_after_ignored_busy", 32'(busy), 32'd0);

    // Mid-frame reset
    start_frame(1'b0);
    wait_beats(500);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_valid", 32'(m_valid), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    start_frame(1'b0);
    check("post_reset_beat0", 32'(m_data), 32'd0);
    wait_done(N + 50);
    @(posedge clk); #1;

    // Back-to-back frames: second start in the done cycle
    start_frame(1'b0);
    wait_done(N + 50);
    b1 = beats;
    start_frame(1'b1);
    wait_done(N + 50);
    check("b2b_total_beats", 32'(b1 + beats), 32'(2 * N));

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_reader.md
CACHE_READER -- requirements
Module: cache_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the memory address width; frame length is N = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a high level in IDLE begins one frame readout.
REQ-006 SHALL have port bit_rev, input, 1 bit: sampled with start; 1 selects bit-reversed address order.
REQ-007 SHALL have port mem_read_adr, output, ADDR_W bits: read address to the frame memory.
REQ-008 SHALL have port mem_rd_en, output, 1 bit: read issued this cycle; the system holds the memory write input low while it is high.
REQ-009 SHALL have port mem_read_data, input, DATA_W bits: registered memory output, valid one cycle after the issuing mem_rd_en.
REQ-010 SHALL have port m_data, output, DATA_W bits: output stream data.
REQ-011 SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-012 SHALL have port m_ready, input, 1 bit: the sink accepts when m_valid and m_ready are both high (a beat).
REQ-013 SHALL have port m_last, output, 1 bit: marks the beat carrying frame index N-1.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the frame completes.

Function
REQ-016 SHALL implement states IDLE, READ and DRAIN.
REQ-017 IDLE SHALL go to READ on start=1; at that edge it latches bit_rev and clears the index counter idx to 0.
REQ-018 In READ, the block SHALL issue a read (mem_rd_en=1) in each cycle where occupancy + inflight - pop < 2, where occupancy is the 2-entry output buffer fill, inflight is the read issued last cycle, and pop is a beat this cycle.
REQ-019 mem_read_adr SHALL be idx when bit_rev is latched 0, and idx with bits reversed (bit k to bit ADDR_W-1-k) when latched 1; idx SHALL increment by 1 on each issued read.
REQ-020 READ SHALL go to DRAIN on the cycle that issues index N-1; no reads SHALL be issued in DRAIN or IDLE, and mem_rd_en SHALL be 0 there.
REQ-021 mem_read_data SHALL be written into the buffer on the edge following each issued read; the buffer is a 2-entry FIFO and never overflows.
REQ-022 m_data and m_valid SHALL come from the buffer head; m_valid SHALL be 1 whenever the buffer is non-empty.
REQ-023 m_last SHALL be 1 only with the head entry tagged as index N-1.
REQ-024 With m_ready held at 1, first m_valid SHALL rise 2 cycles after the start edge, and the block SHALL sustain 1 beat per cycle with no gaps.
REQ-025 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL stay stable.
REQ-026 DRAIN SHALL go to IDLE on the beat with m_last=1; done SHALL be 1 for exactly the following cycle.
REQ-027 start SHALL be ignored outside IDLE; start in the cycle done is high SHALL begin a new frame.
REQ-028 Exactly N beats SHALL be emitted per frame, each index exactly once, in the selected order.

Reset
REQ-029 On rst_n=0, the block SHALL asynchronously enter IDLE and clear idx, buffer occupancy and inflight; mem_rd_en, m_valid, m_last, busy and done SHALL be 0, and mem_read_adr and m_data SHALL be 0.
REQ-030 Reset mid-frame SHALL abandon the frame; no beat SHALL be emitted until a new start after rst_n returns to 1.

Verification
REQ-031 Linear order: preload MEM[i]=i, bit_rev=0, m_ready=1, pulse start -> N consecutive beats 0,1,...,4095; m_last on 4095; done one cycle later.
REQ-032 Bit-reverse order: bit_rev=1 -> beats 0, 2048, 1024, 3072, ...; m_last on beat 4095 (value 4095).
REQ-033 Backpressure: m_ready random 50% -> identical data sequence; data stable while stalled; mem_rd_en never issued with occupancy + inflight - pop = 2.
REQ-034 Ignored start: pulse start at beat 100 -> no restart, still exactly 4096 beats.
REQ-035 Mid-frame reset: assert rst_n=0 at beat 500 -> all outputs 0 at once; a new start gives beats from index 0.
REQ-036 Back-to-back: start asserted in the done cycle -> second frame's first m_valid 2 cycles later; total 8192 beats.
